// File: rtl/raizing_textrom_arbiter.sv
// raizing_textrom_arbiter: round-robin sharing of the single text-ROM read port among N_REQ fetch engines.
// Latency: ACK pulses ROM_LAT cycles after the grant edge (1 cycle on a cache hit when RAIZING_TXTARB_CACHE_EN is defined).
// Backpressure: REQ/ADDR held until ACK; one outstanding read per requester; at most one ROM read issued per cycle.
module raizing_textrom_arbiter #(
    parameter int N_REQ   = 2,
    parameter int AW      = 14,
    parameter int DW      = 16,
    parameter int ROM_LAT = 2
) (
    input  logic                CLK96,
    input  logic                RESET96,
    input  logic [N_REQ-1:0]    REQ,
    input  logic [N_REQ*AW-1:0] ADDR,
    output logic [N_REQ-1:0]    ACK,
    output logic [N_REQ*DW-1:0] DATA,
    output logic [AW-1:0]       ROM_ADDR,
    output logic                ROM_CS,
    input  logic [DW-1:0]       ROM_DATA
);

    localparam int RRW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [RRW-1:0] RR_RST = RRW'(N_REQ - 1);

    logic [N_REQ-1:0][AW-1:0] addr_arr;
    logic [N_REQ-1:0][DW-1:0] data_q;
    logic [N_REQ-1:0]         ack_q;
    logic [N_REQ-1:0]         inflight_q;
    logic [N_REQ-1:0]         eligible;
    logic [RRW-1:0]           rr_q;
    logic [RRW-1:0]           winner;
    logic                     grant;
    logic                     issue;
    logic [AW-1:0]            rom_addr_q;
    logic                     rom_cs_q;

    // Read pipeline: one {valid, id} slot per cycle of ROM latency.
    logic [ROM_LAT-1:0]       pipe_vld;
    logic [RRW-1:0]           pipe_id [ROM_LAT];
    logic                     done_vld;
    logic [RRW-1:0]           done_id;

    assign addr_arr = ADDR;
    assign eligible = REQ & ~inflight_q;
    assign done_vld = pipe_vld[ROM_LAT-1];
    assign done_id  = pipe_id[ROM_LAT-1];

    // Round-robin search starting just after the last winner.
    always_comb begin
        int idx;
        idx    = 0;
        grant  = 1'b0;
        winner = rr_q;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!grant && eligible[idx]) begin
                grant  = 1'b1;
                winner = RRW'(idx);
            end
        end
    end

`ifdef RAIZING_TXTARB_CACHE_EN
    // Single-entry last-read cache; a hit answers from here and skips the ROM.
    logic           cache_vld;
    logic [AW-1:0]  cache_addr;
    logic [DW-1:0]  cache_data;
    logic           hit;
    logic           hit_vld_q;
    logic [RRW-1:0] hit_id_q;
    logic [DW-1:0]  hit_data_q;
    logic [AW-1:0]  pipe_addr [ROM_LAT];

    assign hit   = grant && cache_vld && (addr_arr[winner] == cache_addr);
    assign issue = grant && !hit;

    // Cache fill on every ROM completion plus the one-cycle hit return stage.
    always_ff @(posedge CLK96 or posedge RESET96) begin
        if (RESET96) begin
            cache_vld  <= 1'b0;
            cache_addr <= '0;
            cache_data <= '0;
            hit_vld_q  <= 1'b0;
            hit_id_q   <= '0;
            hit_data_q <= '0;
            for (int i = 0; i < ROM_LAT; i++) begin
                pipe_addr[i] <= '0;
            end
        end else begin
            hit_vld_q    <= hit;
            hit_id_q     <= winner;
            hit_data_q   <= cache_data;
            pipe_addr[0] <= addr_arr[winner];
            for (int i = 1; i < ROM_LAT; i++) begin
                pipe_addr[i] <= pipe_addr[i-1];
            end
            if (done_vld) begin
                cache_vld  <= 1'b1;
                cache_addr <= pipe_addr[ROM_LAT-1];
                cache_data <= ROM_DATA;
            end
        end
    end
`else
    assign issue = grant;
`endif

    // Issue stage: rr pointer, registered ROM address and chip-select strobe.
    always_ff @(posedge CLK96 or posedge RESET96) begin
        if (RESET96) begin
            rr_q       <= RR_RST;
            rom_addr_q <= '0;
            rom_cs_q   <= 1'b0;
        end else begin
            rom_cs_q <= issue;
            if (grant) begin
                rr_q <= winner;
            end
            if (issue) begin
                rom_addr_q <= addr_arr[winner];
            end
        end
    end

    // Shift the issued read's id down the latency pipeline.
    always_ff @(posedge CLK96 or posedge RESET96) begin
        if (RESET96) begin
            pipe_vld <= '0;
            for (int i = 0; i < ROM_LAT; i++) begin
                pipe_id[i] <= '0;
            end
        end else begin
            pipe_vld[0] <= issue;
            pipe_id[0]  <= winner;
            for (int i = 1; i < ROM_LAT; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_id[i]  <= pipe_id[i-1];
            end
        end
    end

    // Completion: capture data, pulse ACK, free the requester; grants mark it busy.
    always_ff @(posedge CLK96 or posedge RESET96) begin
        if (RESET96) begin
            ack_q      <= '0;
            data_q     <= '0;
            inflight_q <= '0;
        end else begin
            ack_q <= '0;
            if (done_vld) begin
                ack_q[done_id]      <= 1'b1;
                data_q[done_id]     <= ROM_DATA;
                inflight_q[done_id] <= 1'b0;
            end
`ifdef RAIZING_TXTARB_CACHE_EN
            if (hit_vld_q) begin
                ack_q[hit_id_q]      <= 1'b1;
                data_q[hit_id_q]     <= hit_data_q;
                inflight_q[hit_id_q] <= 1'b0;
            end
`endif
            // The winner is never the completing id, so this cannot clash with a clear.
            if (grant) begin
                inflight_q[winner] <= 1'b1;
            end
        end
    end

    assign ACK      = ack_q;
    assign DATA     = data_q;
    assign ROM_ADDR = rom_addr_q;
    assign ROM_CS   = rom_cs_q;

endmodule

// File: tb/tb_raizing_textrom_arbiter.sv
// tb_raizing_textrom_arbiter: scoreboard bench for the text-ROM arbiter with a 2-cycle ROM model.
// Latency: expected data queued per requester at request time, compared on each ACK.
// Backpressure: requesters hold REQ/ADDR until ACK, then drop or re-request in the ACK cycle.
module tb_raizing_textrom_arbiter;

    logic        CLK96;
    logic        RESET96;
    logic [1:0]  REQ;
    logic [27:0] ADDR;
    logic [1:0]  ACK;
    logic [31:0] DATA;
    logic [13:0] ROM_ADDR;
    logic        ROM_CS;
    logic [15:0] ROM_DATA;

    int checks = 0;
    int errors = 0;
    int cs_cnt = 0;
    logic [13:0] cs_log [$];
    logic [15:0] q0 [$];
    logic [15:0] q1 [$];
    logic [13:0] rom_q;

    raizing_textrom_arbiter #(.N_REQ(2), .AW(14), .DW(16), .ROM_LAT(2)) dut (
        .CLK96    (CLK96),
        .RESET96  (RESET96),
        .REQ      (REQ),
        .ADDR     (ADDR),
        .ACK      (ACK),
        .DATA     (DATA),
        .ROM_ADDR (ROM_ADDR),
        .ROM_CS   (ROM_CS),
        .ROM_DATA (ROM_DATA)
    );

    initial CLK96 = 1'b0;
    always #5 CLK96 = ~CLK96;

    function automatic logic [15:0] rom_f(input logic [13:0] a);
        if (a == 14'h0123) return 16'hA5A5;
        return {2'b11, a} ^ 16'h0F0F;
    endfunction

    // ROM model: address registered on the edge after ROM_ADDR, data sampled one edge later.
    always @(posedge CLK96) rom_q <= ROM_ADDR;
    assign ROM_DATA = rom_f(rom_q);

    // Scoreboard monitor: logs ROM issues and checks every ACK against queued expectations.
    always @(negedge CLK96) begin
        if (!RESET96) begin
            if (ROM_CS) begin
                cs_cnt++;
                cs_log.push_back(ROM_ADDR);
            end
            if (ACK[0]) begin
                checks++;
                if (q0.size() == 0) begin
                    errors++;
                    $display("FAIL ack0_unexpected: ACK0 with no pending read, DATA0=%h", DATA[15:0]);
                end else begin
                    logic [15:0] e0;
                    e0 = q0.pop_front();
                    if (DATA[15:0] !== e0) begin
                        errors++;
                        $display("FAIL ack0_data: got %h expected %h", DATA[15:0], e0);
                    end
                end
            end
            if (ACK[1]) begin
                checks++;
                if (q1.size() == 0) begin
                    errors++;
                    $display("FAIL ack1_unexpected: ACK1 with no pending read, DATA1=%h", DATA[31:16]);
                end else begin
                    logic [15:0] e1;
                    e1 = q1.pop_front();
                    if (DATA[31:16] !== e1) begin
                        errors++;
                        $display("FAIL ack1_data: got %h expected %h", DATA[31:16], e1);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(negedge CLK96);
        #1;
    endtask

    task automatic req0(input logic [13:0] a);
        ADDR[13:0] = a;
        REQ[0] = 1'b1;
        q0.push_back(rom_f(a));
    endtask

    task automatic req1(input logic [13:0] a);
        ADDR[27:14] = a;
        REQ[1] = 1'b1;
        q1.push_back(rom_f(a));
    endtask

    // Drop each REQ in its ACK cycle until all requesters are idle.
    task automatic drain();
        int n;
        n = 0;
        while (REQ != 2'b00 && n < 40) begin
            tick();
            if (ACK[0]) REQ[0] = 1'b0;
            if (ACK[1]) REQ[1] = 1'b0;
            n++;
        end
        checks++;
        if (REQ != 2'b00) begin
            errors++;
            $display("FAIL drain_timeout: REQ still %b after %0d cycles", REQ, n);
            REQ = 2'b00;
        end
    endtask

    task automatic test_reset();
        RESET96 = 1'b1;
        REQ = 2'b00;
        ADDR = '0;
        tick();
        tick();
        checks++;
        if (ACK !== 2'b00) begin errors++; $display("FAIL reset_ack: got %b expected 00", ACK); end
        checks++;
        if (DATA !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", DATA); end
        checks++;
        if (ROM_CS !== 1'b0) begin errors++; $display("FAIL reset_cs: got %b expected 0", ROM_CS); end
        checks++;
        if (ROM_ADDR !== 14'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0", ROM_ADDR); end
        RESET96 = 1'b0;
        tick();
    endtask

    task automatic test_single();
        int cs_at;
        int ack_at;
        logic [13:0] cs_addr;
        cs_cnt = 0;
        cs_at = -1;
        ack_at = -1;
        cs_addr = '0;
        req0(14'h0123);
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (ROM_CS && cs_at < 0) begin
                cs_at = n;
                cs_addr = ROM_ADDR;
            end
            if (ACK[0]) begin
                ack_at = n;
                REQ[0] = 1'b0;
                break;
            end
        end
        REQ[0] = 1'b0;
        checks++;
        if (cs_at != 1) begin errors++; $display("FAIL single_cs_cycle: got %0d expected 1", cs_at); end
        checks++;
        if (cs_addr !== 14'h0123) begin errors++; $display("FAIL single_rom_addr: got %h expected 0123", cs_addr); end
        checks++;
        if (ack_at != 3) begin errors++; $display("FAIL single_ack_cycle: got %0d expected 3", ack_at); end
        checks++;
        if (DATA[15:0] !== 16'hA5A5) begin errors++; $display("FAIL single_data: got %h expected a5a5", DATA[15:0]); end
        for (int n = 0; n < 4; n++) tick();
        checks++;
        if (cs_cnt != 1) begin errors++; $display("FAIL single_cs_count: got %0d expected 1", cs_cnt); end
    endtask

    task automatic test_contention();
        int n0;
        int n1;
        int cyc;
        logic [13:0] exp_a;
        n0 = 0;
        n1 = 0;
        cyc = 0;
        RESET96 = 1'b1;
        tick();
        req0(14'h0010);
        req1(14'h0020);
        cs_cnt = 0;
        cs_log.delete();
        RESET96 = 1'b0;
        while (REQ != 2'b00 && cyc < 60) begin
            tick();
            cyc++;
            if (ACK[0]) begin
                n0++;
                if (n0 < 4) req0(14'h0010 + 14'(n0));
                else REQ[0] = 1'b0;
            end
            if (ACK[1]) begin
                n1++;
                if (n1 < 4) req1(14'h0020 + 14'(n1));
                else REQ[1] = 1'b0;
            end
        end
        REQ = 2'b00;
        checks++;
        if (n0 != 4 || n1 != 4) begin errors++; $display("FAIL contention_acks: got %0d/%0d expected 4/4", n0, n1); end
        checks++;
        if (cs_log.size() != 8) begin errors++; $display("FAIL contention_cs_count: got %0d expected 8", cs_log.size()); end
        for (int i = 0; i < 8 && i < cs_log.size(); i++) begin
            exp_a = ((i % 2) == 0) ? 14'h0010 + 14'(i / 2) : 14'h0020 + 14'(i / 2);
            checks++;
            if (cs_log[i] !== exp_a) begin
                errors++;
                $display("FAIL contention_order[%0d]: got %h expected %h", i, cs_log[i], exp_a);
            end
        end
    endtask

    task automatic test_back_to_back();
        int n;
        int cyc;
        int last;
        int gap_bad;
        n = 0;
        cyc = 0;
        last = -1;
        gap_bad = 0;
        cs_cnt = 0;
        req0(14'h0100);
        while (REQ[0] && cyc < 80) begin
            tick();
            cyc++;
            if (ACK[0]) begin
                if (last >= 0 && (cyc - last) != 3) gap_bad++;
                last = cyc;
                n++;
                if (n < 8) req0(14'h0100 + 14'(n));
                else REQ[0] = 1'b0;
            end
        end
        REQ[0] = 1'b0;
        checks++;
        if (n != 8) begin errors++; $display("FAIL b2b_acks: got %0d expected 8", n); end
        checks++;
        if (gap_bad != 0) begin errors++; $display("FAIL b2b_spacing: %0d gaps differ from 3 cycles", gap_bad); end
        tick();
        checks++;
        if (cs_cnt != 8) begin errors++; $display("FAIL b2b_cs_count: got %0d expected 8", cs_cnt); end
    endtask

    task automatic test_reset_mid_read();
        int seen;
        int acks;
        seen = 0;
        acks = 0;
        req0(14'h0200);
        for (int n = 0; n < 10 && seen == 0; n++) begin
            tick();
            if (ROM_CS) seen = 1;
        end
        RESET96 = 1'b1;
        REQ = 2'b00;
        q0.delete();
        q1.delete();
        tick();
        checks++;
        if (ACK !== 2'b00 || ROM_CS !== 1'b0) begin
            errors++;
            $display("FAIL midreset_outputs: ACK=%b ROM_CS=%b expected 00/0", ACK, ROM_CS);
        end
        checks++;
        if (DATA !== 32'h0) begin errors++; $display("FAIL midreset_data: got %h expected 0", DATA); end
        tick();
        RESET96 = 1'b0;
        for (int n = 0; n < 6; n++) begin
            tick();
            if (ACK != 2'b00) acks++;
        end
        checks++;
        if (acks != 0) begin errors++; $display("FAIL midreset_stale_ack: got %0d ACK cycles expected 0", acks); end
        cs_log.delete();
        req0(14'h0300);
        req1(14'h0310);
        for (int n = 0; n < 10 && cs_log.size() == 0; n++) tick();
        checks++;
        if (cs_log.size() == 0 || cs_log[0] !== 14'h0300) begin
            errors++;
            $display("FAIL midreset_first_grant: got %h expected 0300", (cs_log.size() == 0) ? 14'h0 : cs_log[0]);
        end
        drain();
    endtask

    task automatic test_drop_in_flight();
        int seen;
        int acks;
        seen = 0;
        acks = 0;
        tick();
        cs_cnt = 0;
        req1(14'h0400);
        for (int n = 0; n < 10 && seen == 0; n++) begin
            tick();
            if (ROM_CS) seen = 1;
        end
        REQ[1] = 1'b0;
        for (int n = 0; n < 6; n++) begin
            tick();
            if (ACK[1]) acks++;
        end
        checks++;
        if (acks != 1) begin errors++; $display("FAIL drop_ack_count: got %0d expected 1", acks); end
        checks++;
        if (cs_cnt != 1) begin errors++; $display("FAIL drop_cs_count: got %0d expected 1", cs_cnt); end
    endtask

    task automatic test_cache();
        int first;
        int m;
        int exp_m;
        int exp_cs;
        first = 0;
        m = 0;
`ifdef RAIZING_TXTARB_CACHE_EN
        exp_m = 2;
        exp_cs = 1;
`else
        exp_m = 3;
        exp_cs = 2;
`endif
        cs_cnt = 0;
        req0(14'h0456);
        for (int n = 0; n < 10 && first == 0; n++) begin
            tick();
            if (ACK[0]) first = 1;
        end
        req0(14'h0456);
        for (int n = 1; n <= 10; n++) begin
            tick();
            if (ACK[0]) begin
                m = n;
                break;
            end
        end
        REQ[0] = 1'b0;
        checks++;
        if (m != exp_m) begin errors++; $display("FAIL cache_second_latency: got %0d expected %0d", m, exp_m); end
        checks++;
        if (DATA[15:0] !== rom_f(14'h0456)) begin
            errors++;
            $display("FAIL cache_data: got %h expected %h", DATA[15:0], rom_f(14'h0456));
        end
        for (int n = 0; n < 4; n++) tick();
        checks++;
        if (cs_cnt != exp_cs) begin errors++; $display("FAIL cache_cs_count: got %0d expected %0d", cs_cnt, exp_cs); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_back_to_back();
        test_reset_mid_read();
        test_drop_in_flight();
        test_cache();
        for (int n = 0; n < 4; n++) tick();
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: %0d/%0d reads never acknowledged", q0.size(), q1.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
